pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC selection, link capture, retire counting.
// Define PC_SEQUENCER_RAS_EN to compile in the return-address stack.
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              jal,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic [31:0]       retire_cnt,
    output logic              misalign,
    output logic              ras_empty,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    if (ADDR_W < 16 || ADDR_W > 32) begin : g_bad_addr_w
        $error("pc_sequencer: ADDR_W must be 16..32");
    end
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two in 2..16");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("pc_sequencer: RESET_PC must be word aligned");
    end

    logic              advance;
    logic              taken;
    logic              use_jr_target;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] branch_target;
    logic [27:0]       jump_low;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] jr_aligned;
    logic [ADDR_W-1:0] jr_dest;
    logic [ADDR_W-1:0] next_pc;

    assign advance       = ~stall;
    assign taken         = branch & zero;
    assign pc4           = pc + ADDR_W'(4);
    assign branch_off    = ADDR_W'($signed(branch_imm)) << 2;
    assign branch_target = pc4 + branch_off;
    assign jump_low      = {jump_idx, 2'b00};
    assign jr_aligned    = {jr_target[ADDR_W-1:2], 2'b00};

    // Narrow address spaces have no upper PC region to preserve across a jump.
    if (ADDR_W > 28) begin : g_jump_region
        assign jump_target = {pc4[ADDR_W-1:28], jump_low};
    end else begin : g_jump_flat
        assign jump_target = jump_low[ADDR_W-1:0];
    end

`ifdef PC_SEQUENCER_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top;
    logic [PTR_W-1:0]  ras_top_next;
    logic [PTR_W-1:0]  ras_wr_idx;
    logic [PTR_W:0]    ras_count;
    logic [PTR_W:0]    ras_count_next;
    logic              ras_full;
    logic              ras_hit;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_ovf_q;
    logic              ras_unf_q;

    assign ras_full = (ras_count == (PTR_W + 1)'(RAS_DEPTH));
    assign ras_hit  = jr && (ras_count != '0);
    assign ras_pop  = advance && ras_hit;
    assign ras_push = advance && jal;

    // The stack is circular: ras_top names the newest entry, so a push while
    // full lands on the oldest slot and the count saturates.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ras_top_next   = ras_top;
        ras_count_next = ras_count;
        ras_wr_idx     = ras_top + PTR_W'(1);
        if (ras_pop && ras_push) begin
            ras_wr_idx = ras_top;
        end else if (ras_push) begin
            ras_top_next = ras_top + PTR_W'(1);
            if (!ras_full) begin
                ras_count_next = ras_count + (PTR_W + 1)'(1);
            end
        end else if (ras_pop) begin
            ras_top_next   = ras_top - PTR_W'(1);
            ras_count_next = ras_count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_top   <= '0;
            ras_count <= '0;
            ras_ovf_q <= 1'b0;
            ras_unf_q <= 1'b0;
        end else begin
            ras_top   <= ras_top_next;
            ras_count <= ras_count_next;
            if (ras_push && !ras_pop && ras_full) begin
                ras_ovf_q <= 1'b1;
            end
            if (advance && jr && !ras_hit) begin
                ras_unf_q <= 1'b1;
            end
        end
    end

    // NOTE: entry storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_wr_idx] <= pc4;
        end
    end

    assign use_jr_target = jr && !ras_hit;
    assign jr_dest       = ras_hit ? ras_mem[ras_top] : jr_aligned;
    assign ras_empty     = (ras_count == '0);
    assign ras_overflow  = ras_ovf_q;
    assign ras_underflow = ras_unf_q;
`else
    assign use_jr_target = jr;
    assign jr_dest       = jr_aligned;
    assign ras_empty     = 1'b1;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        next_pc = pc4;
        if (jr) begin
            next_pc = jr_dest;
        end else if (taken) begin
            next_pc = branch_target;
        end else if (jump) begin
            next_pc = jump_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            link_addr  <= '0;
            retire_cnt <= '0;
            misalign   <= 1'b0;
        end else if (advance) begin
            pc         <= next_pc;
            retire_cnt <= retire_cnt + 32'd1;
            if (jal) begin
                link_addr <= pc4;
            end
            if (use_jr_target && (jr_target[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: a 32-bit and a 16-bit instance share
// stimulus; a queue-based reference model predicts every post-edge state.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct packed {
        bit        rst_n;
        bit        stall;
        bit        branch;
        bit        zero;
        bit        jump;
        bit        jal;
        bit        jr;
        bit [15:0] imm;
        bit [25:0] idx;
        bit [31:0] jrt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] link;
        logic [31:0] ret;
        logic        mis;
        logic        emp;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] branch_imm = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_idx = '0;
    logic        jal = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;

    logic [31:0] pc32, link32, rc32;
    logic        mis32, emp32, ovf32, unf32;
    logic [15:0] pc16, link16;
    logic [31:0] rc16;
    logic        mis16, emp16, ovf16, unf16;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(32), .RAS_DEPTH(4), .RESET_PC(32'h0)) dut32 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
        .branch_imm(branch_imm), .jump(jump), .jump_idx(jump_idx), .jal(jal),
        .jr(jr), .jr_target(jr_target), .pc(pc32), .link_addr(link32),
        .retire_cnt(rc32), .misalign(mis32), .ras_empty(emp32),
        .ras_overflow(ovf32), .ras_underflow(unf32)
    );

    pc_sequencer #(.ADDR_W(16), .RAS_DEPTH(2), .RESET_PC(16'h0010)) dut16 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
        .branch_imm(branch_imm), .jump(jump), .jump_idx(jump_idx), .jal(jal),
        .jr(jr), .jr_target(jr_target[15:0]), .pc(pc16), .link_addr(link16),
        .retire_cnt(rc16), .misalign(mis16), .ras_empty(emp16),
        .ras_overflow(ovf16), .ras_underflow(unf16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint unsigned m_pc [2];
    longint unsigned m_link [2];
    bit [31:0]       m_ret [2];
    bit              m_mis [2];
    bit              m_ovf [2];
    bit              m_unf [2];
    longint unsigned m_stk [2][16];
    int              m_sz [2];

    function automatic longint unsigned mask_of(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic longint unsigned reset_pc_of(input int k);
        return (k == 0) ? 64'h0 : 64'h10;
    endfunction

    task automatic model_step(input int k, input stim_t s);
        longint unsigned msk, pc4, br, jt, jrt, tgt, nxt;
        longint          off;
        if (!s.rst_n) begin
            m_pc[k] = reset_pc_of(k); m_link[k] = 0; m_ret[k] = 0;
            m_mis[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_sz[k] = 0;
            return;
        end
        if (s.stall) return;
        msk = mask_of(k);
        pc4 = (m_pc[k] + 4) & msk;
        off = longint'($signed(s.imm)) * 4;
        br  = (pc4 + longint'(off)) & msk;
        jt  = (((pc4 >> 28) << 28) | (longint'(s.idx) << 2)) & msk;
        jrt = longint'(s.jrt) & msk;
        tgt = 0;
        if (s.jr) begin
            if (RAS && m_sz[k] > 0) begin
                m_sz[k]--;
                tgt = m_stk[k][m_sz[k]];
            end else begin
                tgt = jrt & ~64'd3;
                if ((jrt & 64'd3) != 0) m_mis[k] = 1'b1;
                if (RAS) m_unf[k] = 1'b1;
            end
        end
        if (s.jal) begin
            m_link[k] = pc4;
            if (RAS) begin
                if (m_sz[k] == depth_of(k)) begin
                    for (int j = 0; j < depth_of(k) - 1; j++) m_stk[k][j] = m_stk[k][j+1];
                    m_sz[k]--;
                    m_ovf[k] = 1'b1;
                end
                m_stk[k][m_sz[k]] = pc4;
                m_sz[k]++;
            end
        end
        if (s.jr)                    nxt = tgt;
        else if (s.branch && s.zero) nxt = br;
        else if (s.jump)             nxt = jt;
        else                         nxt = pc4;
        m_pc[k]  = nxt;
        m_ret[k] = m_ret[k] + 32'd1;
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.pc   = m_pc[k][31:0];
        e.link = m_link[k][31:0];
        e.ret  = m_ret[k];
        e.mis  = m_mis[k];
        e.emp  = RAS ? (m_sz[k] == 0) : 1'b1;
        e.ovf  = m_ovf[k];
        e.unf  = m_unf[k];
        return e;
    endfunction

    // ---------------- driver ----------------
    // Applies one cycle of stimulus at the falling edge, records the prediction,
    // and returns just after the rising edge that consumes it.
    task automatic step(input stim_t s);
        @(negedge clk);
        rst_n = s.rst_n; stall = s.stall; branch = s.branch; zero = s.zero;
        branch_imm = s.imm; jump = s.jump; jump_idx = s.idx; jal = s.jal;
        jr = s.jr; jr_target = s.jrt;
        model_step(0, s);
        model_step(1, s);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        started = 1'b1;
        @(posedge clk);
        #2;
    endtask

    function automatic stim_t s_idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t jr_to(input bit [31:0] t);
        stim_t s = s_idle();
        s.jr  = 1'b1;
        s.jrt = t;
        return s;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (q0.size() == 0 || q1.size() == 0) begin
                    check("sb_underrun", 32'(q0.size() + q1.size()), 32'd2);
                end else begin
                    e = q0.pop_front();
                    check("d32.pc", pc32, e.pc);
                    check("d32.link", link32, e.link);
                    check("d32.retire", rc32, e.ret);
                    check("d32.misalign", 32'(mis32), 32'(e.mis));
                    check("d32.empty", 32'(emp32), 32'(e.emp));
                    check("d32.overflow", 32'(ovf32), 32'(e.ovf));
                    check("d32.underflow", 32'(unf32), 32'(e.unf));
                    e = q1.pop_front();
                    check("d16.pc", {16'h0, pc16}, e.pc);
                    check("d16.link", {16'h0, link16}, e.link);
                    check("d16.retire", rc16, e.ret);
                    check("d16.misalign", 32'(mis16), 32'(e.mis));
                    check("d16.empty", 32'(emp16), 32'(e.emp));
                    check("d16.overflow", 32'(ovf16), 32'(e.ovf));
                    check("d16.underflow", 32'(unf16), 32'(e.unf));
                end
            end
        end
    end

    initial begin
        stim_t s;

        // Reset and idle fetch.
        s = s_idle(); s.rst_n = 1'b0;
        step(s);
        step(s);
        check("rst_pc", pc32, 32'h0);
        check("rst_retire", rc32, 32'd0);
        check("rst_pc16", {16'h0, pc16}, 32'h10);
        s = s_idle();
        for (int i = 1; i <= 3; i++) begin
            step(s);
            check("idle_pc", pc32, 32'(4 * i));
        end
        check("idle_retire", rc32, 32'd3);

        // Branch taken / not taken from 0x100.
        step(jr_to(32'h100));
        s = s_idle(); s.branch = 1'b1; s.zero = 1'b1; s.imm = 16'hFFFE;
        step(s);
        check("br_taken_pc", pc32, 32'hFC);
        step(jr_to(32'h100));
        s.zero = 1'b0;
        step(s);
        check("br_not_taken_pc", pc32, 32'h104);

        // Stall holds a pending jump.
        step(jr_to(32'h40));
        s = s_idle(); s.jump = 1'b1; s.idx = 26'h10; s.stall = 1'b1;
        step(s);
        check("stall1_pc", pc32, 32'h40);
        step(s);
        check("stall2_pc", pc32, 32'h40);
        check("stall_retire", rc32, 32'd8);
        s.stall = 1'b0;
        step(s);
        check("jump_pc", pc32, 32'h40);
        check("jump_retire", rc32, 32'd9);

        // 16-bit wrap from 0xFFFC.
        step(jr_to(32'h0000_FFFC));
        check("wrap_pre_pc16", {16'h0, pc16}, 32'hFFFC);
        step(s_idle());
        check("wrap_pc16", {16'h0, pc16}, 32'h0);
        check("wrap_mis16", 32'(mis16), 32'd0);
        check("wrap_pc32", pc32, 32'h1_0000);

        // Misaligned register jump, jalr, then reset mid-run.
        step(jr_to(32'h203));
        check("mis_pc", pc32, 32'h200);
        check("mis_flag", 32'(mis32), 32'd1);
        s = jr_to(32'h300); s.jal = 1'b1;
        step(s);
        check("jalr_link", link32, 32'h204);
        check("jalr_pc", pc32, 32'h300);
        s = s_idle(); s.rst_n = 1'b0; s.stall = 1'b1; s.jump = 1'b1; s.jal = 1'b1;
        step(s);
        check("mid_rst_pc", pc32, 32'h0);
        check("mid_rst_mis", 32'(mis32), 32'd0);
        check("mid_rst_link", link32, 32'h0);
        check("mid_rst_retire", rc32, 32'd0);
        check("mid_rst_empty", 32'(emp32), 32'd1);

        // Call chain deeper than the stack, then unwind.
        s = s_idle();
        for (int i = 0; i < 4; i++) step(s);
        for (int i = 0; i < 5; i++) begin
            s = s_idle(); s.jal = 1'b1; s.jump = 1'b1; s.idx = 26'((32'h20 + 32'h10 * i) >> 2);
            step(s);
        end
        check("call_link", link32, 32'h54);
`ifdef PC_SEQUENCER_RAS_EN
        check("ras_overflow", 32'(ovf32), 32'd1);
        check("ras_underflow_pre", 32'(unf32), 32'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            step(jr_to(32'h80));
`ifdef PC_SEQUENCER_RAS_EN
            check("ras_ret_pc", pc32, (i < 4) ? 32'(32'h54 - 32'h10 * i) : 32'h80);
`else
            check("jr_ret_pc", pc32, 32'h80);
`endif
        end
`ifdef PC_SEQUENCER_RAS_EN
        check("ras_underflow", 32'(unf32), 32'd1);
`endif

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            s = s_idle();
            s.rst_n  = ($urandom_range(0, 39) != 0);
            s.stall  = ($urandom_range(0, 3) == 0);
            s.branch = 1'($urandom_range(0, 1));
            s.zero   = 1'($urandom_range(0, 1));
            s.jump   = ($urandom_range(0, 3) == 0);
            s.jal    = ($urandom_range(0, 4) == 0);
            s.jr     = ($urandom_range(0, 5) == 0);
            s.imm    = 16'($urandom);
            s.idx    = 26'($urandom);
            s.jrt    = $urandom;
            if ($urandom_range(0, 7) != 0) s.jrt[1:0] = 2'b00;
            step(s);
        end

        started = 1'b0;
        check("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
